// File: rtl/rs_bank_pkg.sv
// Shared types and default sizing for the reservation-station bank.
// Holds the dispatch payload type, default bank geometry and the
// global slot identifier type used by dependency masks.
package rs_bank_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int NUM_FUS    = 4;
    localparam int SLOT_W     = $clog2(RS_ENTRIES);
    localparam int GSLOT_W    = $clog2(RS_ENTRIES * NUM_FUS);

    // Global slot ID: FU index * RS_ENTRIES + local slot.
    typedef logic [GSLOT_W-1:0] gslot_id_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  rd;
        logic [31:0] imm;
    } disp_packet_t;

    // Global slot ID of a local slot in a given FU's bank.
    function automatic gslot_id_t make_gslot(input int fu, input int slot);
        return gslot_id_t'(fu * RS_ENTRIES + slot);
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for oldest-first selection among the bank's entries.
// older_reg[i][j] = 1 means entry i is older than entry j. A newly
// allocated entry is younger than every live entry; a freed entry drops
// out of all comparisons. The grant is the requester with no older
// requester, so it is always one-hot (or zero when nothing requests).
module rs_age_matrix #(
    parameter int RS_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RS_ENTRIES-1:0] alloc_oh,
    input  logic [RS_ENTRIES-1:0] free_oh,
    input  logic                  flush,
    input  logic [RS_ENTRIES-1:0] req,
    output logic [RS_ENTRIES-1:0] grant
);

    logic [RS_ENTRIES-1:0] older_reg [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] blocked;

    for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_row
        // Row update: new or freed entries are older than nobody; other
        // rows gain the new entry and lose the freed one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                older_reg[gi] <= '0;
            end else if (flush) begin
                older_reg[gi] <= '0;
            end else if (alloc_oh[gi] || free_oh[gi]) begin
                older_reg[gi] <= '0;
            end else begin
                older_reg[gi] <= (older_reg[gi] & ~free_oh) | alloc_oh;
            end
        end
    end

    // A requester is granted when no other requester is older than it.
    always_comb begin
        blocked = '0;
        grant   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (req[j] && older_reg[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            grant[i] = req[i] && !blocked[i];
        end
    end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank for one functional unit.
// Accepts dispatch packets with dependency masks, clears mask bits on
// wakeup broadcasts (including the packet being dispatched this cycle),
// and issues the oldest ready entry through a registered valid/ready stage.
// Optional feature macro: RS_OCCUPANCY_EN adds the rs_occupancy counter.
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int FU_ID      = 0,
    parameter int RS_ENTRIES = rs_bank_pkg::RS_ENTRIES,
    parameter int NUM_FUS    = rs_bank_pkg::NUM_FUS,
    localparam int SLOT_W    = $clog2(RS_ENTRIES),
    localparam int MASK_W    = RS_ENTRIES * NUM_FUS,
    localparam int OCC_W     = $clog2(RS_ENTRIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        disp_valid,
    input  disp_packet_t                disp_pkt,
    input  logic [MASK_W-1:0]           dependency_mask,
    output logic [SLOT_W-1:0]           rs_entry_idx,
    output logic                        rs_full,
    input  logic                        flush,
    input  logic [NUM_FUS-1:0]          wake_valid,
    input  logic [NUM_FUS*SLOT_W-1:0]   wake_slot,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output disp_packet_t                issue_pkt,
    output logic [SLOT_W-1:0]           issue_slot
`ifdef RS_OCCUPANCY_EN
    ,
    output logic [OCC_W-1:0]            rs_occupancy
`endif
);

    // Entry storage
    logic                valid_reg [RS_ENTRIES];
    disp_packet_t        pkt_reg   [RS_ENTRIES];
    logic [MASK_W-1:0]   mask_reg  [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] valid_vec;

    // Allocation / wakeup / select
    logic [SLOT_W-1:0]     alloc_idx;
    logic                  accept;
    logic [RS_ENTRIES-1:0] alloc_oh;
    logic [MASK_W-1:0]     wake_clr;
    logic [RS_ENTRIES-1:0] ready_vec;
    logic [RS_ENTRIES-1:0] grant_oh;
    logic [RS_ENTRIES-1:0] free_oh;
    logic [SLOT_W-1:0]     grant_idx;
    logic                  load_issue;
    disp_packet_t          sel_pkt;

    // Issue register
    logic                  issue_valid_reg;
    disp_packet_t          issue_pkt_reg;
    logic [SLOT_W-1:0]     issue_slot_reg;

    for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_vec
        assign valid_vec[gi] = valid_reg[gi];
        assign ready_vec[gi] = valid_reg[gi] && (mask_reg[gi] == '0);
        assign alloc_oh[gi]  = accept && (alloc_idx == SLOT_W'(gi));
    end

    // Each global mask bit belongs to exactly one FU; clear it when that
    // FU broadcasts the matching local slot.
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_wake
        assign wake_clr[gi] = wake_valid[gi / RS_ENTRIES] &&
            (wake_slot[(gi / RS_ENTRIES) * SLOT_W +: SLOT_W] == SLOT_W'(gi % RS_ENTRIES));
    end

    // Lowest-index free slot; a slot freed this cycle is not visible yet.
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_idx = SLOT_W'(i);
            end
        end
    end

    assign rs_full      = &valid_vec;
    assign rs_entry_idx = alloc_idx;
    assign accept       = disp_valid && !rs_full;

    rs_age_matrix #(
        .RS_ENTRIES (RS_ENTRIES)
    ) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_oh (alloc_oh),
        .free_oh  (free_oh),
        .flush    (flush),
        .req      (ready_vec),
        .grant    (grant_oh)
    );

    // Encode the one-hot oldest grant into a slot index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (grant_oh[i]) begin
                grant_idx = grant_idx | SLOT_W'(i);
            end
        end
    end

    assign sel_pkt    = pkt_reg[grant_idx];
    assign load_issue = (!issue_valid_reg || issue_ready) && (|ready_vec);
    assign free_oh    = load_issue ? grant_oh : '0;

    for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
        // Entry valid: set on allocate, cleared when moved to the issue register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
            end else if (flush) begin
                valid_reg[gi] <= 1'b0;
            end else if (alloc_oh[gi]) begin
                valid_reg[gi] <= 1'b1;
            end else if (free_oh[gi]) begin
                valid_reg[gi] <= 1'b0;
            end
        end

        // Payload and mask; wakeups apply to the incoming mask too.
        always_ff @(posedge clk) begin
            if (alloc_oh[gi]) begin
                pkt_reg[gi]  <= disp_pkt;
                mask_reg[gi] <= dependency_mask & ~wake_clr;
            end else begin
                mask_reg[gi] <= mask_reg[gi] & ~wake_clr;
            end
        end
    end

    // Issue register: load when empty or draining, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_reg <= 1'b0;
            issue_pkt_reg   <= '0;
            issue_slot_reg  <= '0;
        end else if (flush) begin
            issue_valid_reg <= 1'b0;
        end else if (load_issue) begin
            issue_valid_reg <= 1'b1;
            issue_pkt_reg   <= sel_pkt;
            issue_slot_reg  <= grant_idx;
        end else if (issue_ready) begin
            issue_valid_reg <= 1'b0;
        end
    end

    assign issue_valid = issue_valid_reg;
    assign issue_pkt   = issue_pkt_reg;
    assign issue_slot  = issue_slot_reg;

    // An entry may never wait on its own global slot.
    logic [MASK_W-1:0] self_bit_vec;
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_self
        assign self_bit_vec[gi] = (gi / RS_ENTRIES == FU_ID) &&
                                  (alloc_idx == SLOT_W'(gi % RS_ENTRIES));
    end

    a_no_self_dep: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && !flush) |-> ((dependency_mask & self_bit_vec) == '0));

`ifdef RS_OCCUPANCY_EN
    logic [OCC_W-1:0] occ_reg;

    // Occupancy counter: +1 on accept, -1 on move to issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else begin
            case ({accept, load_issue})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign rs_occupancy = occ_reg;

    a_occ_matches: assert property (@(posedge clk) disable iff (!rst_n)
        int'(occ_reg) == $countones(valid_vec));
`endif

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed scenarios plus random traffic,
// all checked against an entry-list reference model (sequence numbers for age).
module tb_rs_bank;
    import rs_bank_pkg::*;

    localparam int RS = 8;
    localparam int NF = 4;
    localparam int SW = 3;
    localparam int MW = RS * NF;

    logic              clk;
    logic              rst_n;
    logic              disp_valid;
    disp_packet_t      disp_pkt;
    logic [MW-1:0]     dependency_mask;
    logic [SW-1:0]     rs_entry_idx;
    logic              rs_full;
    logic              flush;
    logic [NF-1:0]     wake_valid;
    logic [NF*SW-1:0]  wake_slot;
    logic              issue_valid;
    logic              issue_ready;
    disp_packet_t      issue_pkt;
    logic [SW-1:0]     issue_slot;
`ifdef RS_OCCUPANCY_EN
    logic [3:0]        rs_occupancy;
`endif

    rs_bank #(.FU_ID(0), .RS_ENTRIES(RS), .NUM_FUS(NF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .disp_valid      (disp_valid),
        .disp_pkt        (disp_pkt),
        .dependency_mask (dependency_mask),
        .rs_entry_idx    (rs_entry_idx),
        .rs_full         (rs_full),
        .flush           (flush),
        .wake_valid      (wake_valid),
        .wake_slot       (wake_slot),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_pkt       (issue_pkt),
        .issue_slot      (issue_slot)
`ifdef RS_OCCUPANCY_EN
        ,
        .rs_occupancy    (rs_occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: entries with a sequence number for age.
    bit           m_valid [RS];
    logic [MW-1:0] m_mask [RS];
    disp_packet_t m_pkt   [RS];
    int           m_seq   [RS];
    int           seq_ctr;
    bit           m_iv;
    disp_packet_t m_ipkt;
    logic [SW-1:0] m_islot;

    function automatic disp_packet_t rand_pkt();
        disp_packet_t p;
        p.opcode = 8'($urandom);
        p.rd     = 6'($urandom);
        p.imm    = $urandom;
        return p;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) if (!m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [SW-1:0] model_free_idx();
        for (int i = 0; i < RS; i++) if (!m_valid[i]) return SW'(i);
        return '0;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < RS; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) begin
            m_valid[i] = 1'b0;
            m_mask[i]  = '0;
            m_seq[i]   = 0;
        end
        seq_ctr = 0;
        m_iv    = 1'b0;
        m_ipkt  = '0;
        m_islot = '0;
    endtask

    // Apply one clock edge worth of the bank's rules to the model.
    task automatic model_update();
        logic [MW-1:0] clr;
        bit full;
        logic [SW-1:0] idx;
        int sel;
        bit load;
        clr = '0;
        for (int f = 0; f < NF; f++)
            if (wake_valid[f]) clr[f * RS + int'(wake_slot[f * SW +: SW])] = 1'b1;
        if (flush) begin
            for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
            m_iv = 1'b0;
            return;
        end
        full = model_full();
        idx  = model_free_idx();
        sel  = -1;
        for (int i = 0; i < RS; i++)
            if (m_valid[i] && m_mask[i] == '0 && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
        load = (!m_iv || issue_ready) && (sel >= 0);
        for (int i = 0; i < RS; i++) m_mask[i] = m_mask[i] & ~clr;
        if (load) begin
            m_iv           = 1'b1;
            m_ipkt         = m_pkt[sel];
            m_islot        = SW'(sel);
            m_valid[sel]   = 1'b0;
        end else if (issue_ready) begin
            m_iv = 1'b0;
        end
        if (disp_valid && !full) begin
            m_valid[idx] = 1'b1;
            m_pkt[idx]   = disp_pkt;
            m_mask[idx]  = dependency_mask & ~clr;
            m_seq[idx]   = seq_ctr;
            seq_ctr++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        disp_valid      = 1'b0;
        disp_pkt        = '0;
        dependency_mask = '0;
        flush           = 1'b0;
        wake_valid      = '0;
        wake_slot       = '0;
    endtask

    task automatic test_reset();
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset issue_valid got %0b want 0", issue_valid); end
        total++; if (issue_pkt !== '0) begin bad++; $display("FAIL reset issue_pkt got %h want 0", issue_pkt); end
        total++; if (issue_slot !== '0) begin bad++; $display("FAIL reset issue_slot got %0d want 0", issue_slot); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset rs_full got %0b want 0", rs_full); end
        total++; if (rs_entry_idx !== '0) begin bad++; $display("FAIL reset rs_entry_idx got %0d want 0", rs_entry_idx); end
`ifdef RS_OCCUPANCY_EN
        total++; if (rs_occupancy !== '0) begin bad++; $display("FAIL reset rs_occupancy got %0d want 0", rs_occupancy); end
`endif
        $display("reset: issue_valid=%0b rs_full=%0b idx=%0d", issue_valid, rs_full, rs_entry_idx);
    endtask

    task automatic test_fill();
        issue_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            disp_valid      = 1'b1;
            disp_pkt        = rand_pkt();
            dependency_mask = '0;
            total++; if (rs_entry_idx !== model_free_idx()) begin bad++; $display("FAIL fill idx k=%0d got %0d want %0d", k, rs_entry_idx, model_free_idx()); end
            total++; if (rs_full !== model_full()) begin bad++; $display("FAIL fill rs_full k=%0d got %0b want %0b", k, rs_full, model_full()); end
            $display("fill: k=%0d idx=%0d full=%0b", k, rs_entry_idx, rs_full);
            tick();
        end
        clear_inputs();
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL fill issue_valid got %0b want 1", issue_valid); end
        total++; if (issue_slot !== 3'd0) begin bad++; $display("FAIL fill issue_slot got %0d want 0", issue_slot); end
        total++; if (issue_pkt !== m_ipkt) begin bad++; $display("FAIL fill issue_pkt got %h want %h", issue_pkt, m_ipkt); end
        total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL fill rs_full after 9 accepts got %0b want 1", rs_full); end
        issue_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            total++; if (issue_valid !== m_iv) begin bad++; $display("FAIL drain issue_valid c=%0d got %0b want %0b", c, issue_valid, m_iv); end
            if (m_iv) begin
                total++; if (issue_slot !== m_islot || issue_pkt !== m_ipkt) begin bad++; $display("FAIL drain issue c=%0d got slot %0d pkt %h want slot %0d pkt %h", c, issue_slot, issue_pkt, m_islot, m_ipkt); end
            end
            $display("drain: c=%0d valid=%0b slot=%0d", c, issue_valid, issue_slot);
            tick();
        end
    endtask

    task automatic test_wakeup_order();
        disp_packet_t pa, pb;
        pa = rand_pkt();
        pb = rand_pkt();
        issue_ready = 1'b1;
        disp_valid = 1'b1; disp_pkt = pa; dependency_mask = MW'(1) << 9;
        total++; if (rs_entry_idx !== 3'd0) begin bad++; $display("FAIL wake A idx got %0d want 0", rs_entry_idx); end
        tick();
        disp_pkt = pb; dependency_mask = '0;
        tick();
        clear_inputs();
        tick();
        total++; if (issue_valid !== 1'b1 || issue_slot !== 3'd1 || issue_pkt !== pb) begin bad++; $display("FAIL wake B-first got v=%0b slot=%0d pkt=%h want v=1 slot=1 pkt=%h", issue_valid, issue_slot, issue_pkt, pb); end
        $display("wake: B issued slot=%0d", issue_slot);
        wake_valid = 4'b0010;
        wake_slot[SW +: SW] = 3'd1;
        tick();
        clear_inputs();
        tick();
        total++; if (issue_valid !== 1'b1 || issue_slot !== 3'd0 || issue_pkt !== pa) begin bad++; $display("FAIL wake A-after got v=%0b slot=%0d pkt=%h want v=1 slot=0 pkt=%h", issue_valid, issue_slot, issue_pkt, pa); end
        $display("wake: A issued slot=%0d", issue_slot);
    endtask

    task automatic test_bypass();
        disp_packet_t pc;
        pc = rand_pkt();
        issue_ready = 1'b1;
        disp_valid = 1'b1; disp_pkt = pc; dependency_mask = MW'(1) << 2;
        wake_valid = 4'b0001;
        wake_slot[0 +: SW] = 3'd2;
        tick();
        clear_inputs();
        total++; if (issue_valid !== m_iv) begin bad++; $display("FAIL bypass mid issue_valid got %0b want %0b", issue_valid, m_iv); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_pkt !== pc) begin bad++; $display("FAIL bypass issue got v=%0b pkt=%h want v=1 pkt=%h", issue_valid, issue_pkt, pc); end
        $display("bypass: valid=%0b pkt=%h", issue_valid, issue_pkt);
        tick();
    endtask

    task automatic test_hold();
        disp_packet_t p [3];
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            p[k] = rand_pkt();
            disp_valid = 1'b1; disp_pkt = p[k]; dependency_mask = '0;
            tick();
        end
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            total++; if (issue_valid !== 1'b1 || issue_pkt !== p[0] || issue_slot !== m_islot) begin bad++; $display("FAIL hold c=%0d got v=%0b pkt=%h slot=%0d want v=1 pkt=%h slot=%0d", c, issue_valid, issue_pkt, issue_slot, p[0], m_islot); end
            $display("hold: c=%0d pkt=%h slot=%0d", c, issue_pkt, issue_slot);
            tick();
        end
        issue_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            total++; if (issue_valid !== 1'b1 || issue_pkt !== p[k] || issue_slot !== m_islot) begin bad++; $display("FAIL hold order k=%0d got v=%0b pkt=%h slot=%0d want pkt=%h slot=%0d", k, issue_valid, issue_pkt, issue_slot, p[k], m_islot); end
            $display("release: k=%0d pkt=%h slot=%0d", k, issue_pkt, issue_slot);
        end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL hold empty issue_valid got %0b want 0", issue_valid); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp_valid = 1'b1; disp_pkt = rand_pkt();
            dependency_mask = (k == 0) ? '0 : (MW'(1) << 20);
            tick();
        end
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL flush pre issue_valid got %0b want 1", issue_valid); end
        flush = 1'b1; disp_valid = 1'b1; disp_pkt = rand_pkt(); dependency_mask = '0;
        tick();
        clear_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush issue_valid got %0b want 0", issue_valid); end
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL flush rs_full got %0b want 0", rs_full); end
        total++; if (rs_entry_idx !== 3'd0) begin bad++; $display("FAIL flush idx got %0d want 0", rs_entry_idx); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush no-alloc issue_valid got %0b want 0", issue_valid); end
`ifdef RS_OCCUPANCY_EN
        total++; if (rs_occupancy !== '0) begin bad++; $display("FAIL flush rs_occupancy got %0d want 0", rs_occupancy); end
`endif
        $display("flush: issue_valid=%0b idx=%0d full=%0b", issue_valid, rs_entry_idx, rs_full);
    endtask

    task automatic test_random();
        logic [SW-1:0] idx;
        for (int c = 0; c < 300; c++) begin
            idx = model_free_idx();
            disp_valid = ($urandom_range(0, 2) != 0);
            disp_pkt   = rand_pkt();
            dependency_mask = '0;
            if ($urandom_range(0, 1) == 1) dependency_mask[$urandom_range(0, MW - 1)] = 1'b1;
            dependency_mask[idx] = 1'b0;
            for (int f = 0; f < NF; f++) begin
                wake_valid[f] = ($urandom_range(0, 2) == 0);
                wake_slot[f * SW +: SW] = SW'($urandom_range(0, RS - 1));
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
            total++; if (issue_valid !== m_iv) begin bad++; $display("FAIL rand issue_valid c=%0d got %0b want %0b", c, issue_valid, m_iv); end
            if (m_iv) begin
                total++; if (issue_pkt !== m_ipkt || issue_slot !== m_islot) begin bad++; $display("FAIL rand issue c=%0d got slot %0d pkt %h want slot %0d pkt %h", c, issue_slot, issue_pkt, m_islot, m_ipkt); end
            end
            total++; if (rs_full !== model_full()) begin bad++; $display("FAIL rand rs_full c=%0d got %0b want %0b", c, rs_full, model_full()); end
            total++; if (rs_entry_idx !== idx) begin bad++; $display("FAIL rand idx c=%0d got %0d want %0d", c, rs_entry_idx, idx); end
`ifdef RS_OCCUPANCY_EN
            total++; if (int'(rs_occupancy) != model_count()) begin bad++; $display("FAIL rand rs_occupancy c=%0d got %0d want %0d", c, rs_occupancy, model_count()); end
`endif
            $display("rand: c=%0d dv=%0b ir=%0b fl=%0b iv=%0b slot=%0d cnt=%0d", c, disp_valid, issue_ready, flush, issue_valid, issue_slot, model_count());
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        clear_inputs();
        issue_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            disp_valid = 1'b1; disp_pkt = rand_pkt();
            dependency_mask = (k == 0) ? '0 : (MW'(1) << 30);
            tick();
        end
        clear_inputs();
        total++; if (issue_valid !== 1'b1 || model_count() != 5) begin bad++; $display("FAIL arst pre got issue_valid %0b entries %0d want 1 and 5", issue_valid, model_count()); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL arst issue_valid got %0b want 0", issue_valid); end
        total++; if (issue_pkt !== '0 || issue_slot !== '0) begin bad++; $display("FAIL arst issue regs got pkt %h slot %0d want 0", issue_pkt, issue_slot); end
        total++; if (rs_full !== 1'b0 || rs_entry_idx !== '0) begin bad++; $display("FAIL arst alloc got full %0b idx %0d want 0", rs_full, rs_entry_idx); end
`ifdef RS_OCCUPANCY_EN
        total++; if (rs_occupancy !== '0) begin bad++; $display("FAIL arst rs_occupancy got %0d want 0", rs_occupancy); end
`endif
        $display("arst: issue_valid=%0b full=%0b idx=%0d", issue_valid, rs_full, rs_entry_idx);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL arst post issue_valid got %0b want 0", issue_valid); end
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_ready = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fill();
        test_wakeup_order();
        test_bypass();
        test_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
